// File: rtl/onehot_rr_arbiter.sv
// onehot_rr_arbiter: round-robin arbiter with a registered one-hot grant,
// a matching binary index, and a sticky protocol-error flag.
// A grant is held until the burst ends (xfer && xfer_last) or its request
// drops. After each release there is always one idle cycle, and the search
// pointer moves to just past the released requester.
// Optional feature: define ONEHOT_ARB_HOLD_LIMIT_EN to add a hold limit.
// With it, a grant held for HOLD_MAX cycles is pre-empted when another
// requester is waiting.
module onehot_rr_arbiter #(
  parameter int CNT      = 5,
  parameter int IDXW     = 3,
  parameter int HOLD_MAX = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CNT-1:0]  req,
  input  logic            xfer,
  input  logic            xfer_last,
  output logic [CNT-1:0]  gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            busy,
  output logic            err
);

  // Reject illegal parameter combinations at elaboration time.
  if (CNT < 2 || CNT > 32 || HOLD_MAX < 1 || HOLD_MAX > 255 ||
      IDXW < $clog2(CNT)) begin : g_bad_param
    $error("onehot_rr_arbiter: illegal parameter value");
  end

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          state, state_nxt;
  logic [CNT-1:0]  gnt_nxt;
  logic [IDXW-1:0] gnt_idx_nxt;
  logic [IDXW-1:0] ptr, ptr_nxt;
  logic            err_nxt;
  logic [IDXW-1:0] pick_idx;
  logic            release_ev;
  logic            hold_expire;

  // Round-robin pick: take the lowest set request at or above ptr.
  // If there is none, wrap around and take the lowest set request overall.
  always_comb begin
    logic            hi_found;
    logic [IDXW-1:0] hi_idx;
    logic [IDXW-1:0] lo_idx;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = CNT - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IDXW'(i);
        if (i >= int'(ptr)) begin
          hi_found = 1'b1;
          hi_idx   = IDXW'(i);
        end
      end
    end
    pick_idx = hi_found ? hi_idx : lo_idx;
  end

`ifdef ONEHOT_ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] hold_cnt;
  logic       hold_at_max;
  logic       others_req;

  assign hold_at_max = (hold_cnt == HOLD_LAST);
  assign others_req  = |(req & ~gnt);
  assign hold_expire = (state == S_GRANT) && hold_at_max && others_req;

  // Hold counter: it is zero on the first grant cycle and counts each
  // further grant cycle. On expiry it restarts, which matters when no
  // other requester is waiting and the grant is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hold_cnt <= '0;
    else if (state != S_GRANT || hold_at_max)
      hold_cnt <= '0;
    else
      hold_cnt <= hold_cnt + 8'd1;
  end
`else
  assign hold_expire = 1'b0;
`endif

  // Release when the burst ends, when the granted request drops, or when
  // the hold limit expires. The grant is one-hot, so req & gnt == 0 means
  // req[gnt_idx] is low.
  assign release_ev = (xfer && xfer_last) || ((req & gnt) == '0) || hold_expire;

  // Next-state and next-output logic for the IDLE/GRANT machine.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_nxt   = state;
    gnt_nxt     = gnt;
    gnt_idx_nxt = gnt_idx;
    ptr_nxt     = ptr;
    err_nxt     = err || (state == S_IDLE && xfer);
    case (state)
      S_IDLE: begin
        if (|req) begin
          state_nxt   = S_GRANT;
          gnt_nxt     = CNT'(1) << pick_idx;
          gnt_idx_nxt = pick_idx;
        end
      end
      S_GRANT: begin
        if (release_ev) begin
          state_nxt   = S_IDLE;
          gnt_nxt     = '0;
          gnt_idx_nxt = '0;
          ptr_nxt     = (gnt_idx == IDXW'(CNT - 1)) ? '0 : gnt_idx + IDXW'(1);
        end
      end
      default: begin
        state_nxt   = S_IDLE;
        gnt_nxt     = '0;
        gnt_idx_nxt = '0;
      end
    endcase
  end

  // State and output registers. Reset clears them at once, even mid-grant.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge.
    if (!rst_n) begin
      state   <= S_IDLE;
      gnt     <= '0;
      gnt_idx <= '0;
      busy    <= 1'b0;
      err     <= 1'b0;
      ptr     <= '0;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      gnt_idx <= gnt_idx_nxt;
      busy    <= (state_nxt == S_GRANT);
      err     <= err_nxt;
      ptr     <= ptr_nxt;
    end
  end

endmodule

// File: doc/onehot_rr_arbiter.md
ONEHOT_RR_ARBITER -- requirements
Module: onehot_rr_arbiter

Interface
REQ-001 SHALL have parameter CNT, default 5, number of requesters and width of the one-hot grant; legal range 2..32.
REQ-002 SHALL have parameter IDXW, default 3, width of the binary grant index; IDXW >= ceil(log2(CNT)).
REQ-003 SHALL have parameter HOLD_MAX, default 16, maximum cycles one grant is held under the hold limit; legal range 1..255.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req  input  CNT  level request per requester, bit i = requester i.
REQ-007 SHALL have port xfer  input  1  one beat of the granted source accepted downstream this cycle.
REQ-008 SHALL have port xfer_last  input  1  qualifies xfer as the final beat of the granted burst.
REQ-009 SHALL have port gnt  output  CNT  registered one-hot grant, drives the select of a one-hot data mux.
REQ-010 SHALL have port gnt_idx  output  IDXW  registered binary index of the granted requester, 0 when idle.
REQ-011 SHALL have port busy  output  1  registered, high whenever gnt is non-zero.
REQ-012 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-013 SHALL implement a two-state FSM: IDLE (gnt=0) and GRANT (exactly one gnt bit set).
REQ-014 In IDLE with req non-zero, SHALL select the first set req bit searching upward from pointer ptr with wrap from CNT-1 to 0, and assert the grant on the next rising edge (1-cycle latency from req to gnt).
REQ-015 In IDLE with req all zero, SHALL stay in IDLE with gnt, gnt_idx and busy at 0.
REQ-016 In GRANT, gnt and gnt_idx SHALL remain constant until a release event.
REQ-017 Release events: (a) xfer and xfer_last both high; (b) req[gnt_idx] low; (c) hold-limit expiry (REQ-026).
REQ-018 On a release event, the next cycle SHALL be IDLE with gnt=0, and ptr SHALL become gnt_idx+1, wrapping CNT-1 to 0.
REQ-019 Release SHALL always insert exactly one IDLE cycle before the next grant, even with requests pending; a re-request by the releasing source is served only after others at or above the new ptr.
REQ-020 xfer without xfer_last in GRANT SHALL NOT change the grant.
REQ-021 xfer high while in IDLE SHALL set err on the next edge; err SHALL stay high until reset.
REQ-022 xfer_last high without xfer SHALL be ignored.
REQ-023 gnt SHALL never have more than one bit set, and gnt_idx SHALL always equal the index of the set bit.
REQ-024 Simultaneous release event and req change SHALL be resolved by release first; the new req is evaluated in the following IDLE cycle.

Reset
REQ-025 On rst_n low, SHALL asynchronously force state to IDLE, gnt=0, gnt_idx=0, busy=0, err=0, ptr=0 and hold counter=0, including mid-grant; the first arbitration after deassertion SHALL start from requester 0.

Configuration
REQ-026 With macro ONEHOT_ARB_HOLD_LIMIT_EN defined: an 8-bit counter SHALL clear on grant entry and increment each GRANT cycle; when it reaches HOLD_MAX-1 and any other req bit is set, the next edge SHALL release the grant as in REQ-018, and an expiry with no other requester SHALL clear the counter and keep the grant.
REQ-027 Without ONEHOT_ARB_HOLD_LIMIT_EN, SHALL contain no hold counter, and grants SHALL be released only by REQ-017(a) and (b).

Verification
REQ-028 Reset, req=5'b00101 at cycle 0 -> gnt=5'b00001, gnt_idx=0 at cycle 1; xfer+xfer_last at cycle 3 -> gnt=0 at cycle 4, gnt=5'b00100, gnt_idx=2 at cycle 5.
REQ-029 Wrap: with ptr=4 after serving requester 3, req=5'b10001 -> gnt=5'b10000; after release -> gnt=5'b00001.
REQ-030 Grant held through 3 xfer beats without xfer_last, with req=5'b11111 constant -> gnt unchanged; dropping req[gnt_idx] -> gnt=0 next cycle.
REQ-031 xfer=1 while IDLE -> err=1 next cycle and remains 1 across later grants until rst_n low.
REQ-032 With ONEHOT_ARB_HOLD_LIMIT_EN and HOLD_MAX=4, req=5'b00011, no xfer -> gnt=5'b00001 for 4 cycles, 1 IDLE cycle, then gnt=5'b00010; with req=5'b00001 only, the grant is held indefinitely.
REQ-033 rst_n asserted mid-grant -> gnt=0, busy=0 immediately without a clock edge; after deassertion with req=5'b11111 -> gnt=5'b00001.
